// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory read, PC-tagged instruction FIFO, redirect flush.
// Optional FETCH_STATS_EN adds saturating fetch/stall counters.
module fetch_unit #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic              flush,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              pc_advance,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_STATS_EN
  ,output logic [31:0]       stat_fetched,
   output logic [31:0]       stat_stall
`endif
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t state, state_next;

   logic [ADDR_W+DATA_W-1:0] buf_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [CNT_W-1:0]         count, count_next;
   logic                     handshake, push, pop, issue;

   assign handshake = (state == REQ) && mem_req_ready;
   assign push      = (state == WAIT) && mem_rsp_valid && !flush;
   assign pop       = (count != '0) && inst_ready && !flush;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + CNT_W'(1);
      else if (pop && !push)
         count_next = count - CNT_W'(1);
   end

   // Slot check uses post-push/pop occupancy so the in-flight response always has room.
   assign issue = fetch_en && !flush && (count_next < CNT_W'(FIFO_DEPTH));

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (issue) state_next = REQ;
         REQ: begin
            if (flush)          state_next = handshake ? DROP : IDLE;
            else if (handshake) state_next = WAIT;
         end
         WAIT: begin
            if (flush)              state_next = mem_rsp_valid ? IDLE : DROP;
            else if (mem_rsp_valid) state_next = issue ? REQ : IDLE;
         end
         DROP: if (mem_rsp_valid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign pc_advance    = handshake && !flush;
   assign mem_req_valid = (state == REQ);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         mem_req_addr <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
      end else begin
         state <= state_next;
         if (state_next == REQ && state != REQ)
            mem_req_addr <= pc_in;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         buf_mem[wr_ptr] <= {mem_req_addr, mem_rsp_data};
   end

   assign inst_valid          = (count != '0);
   assign {inst_pc, inst_data} = inst_valid ? buf_mem[rd_ptr] : '0;

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_fetched <= '0;
         stat_stall   <= '0;
      end else begin
         if (push && stat_fetched != '1)
            stat_fetched <= stat_fetched + 32'd1;
         if (!inst_valid && fetch_en && stat_stall != '1)
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: bench-side memory model pushes expected {pc,data}, a monitor pops on consume.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic        flush;
   logic [31:0] pc_in;
   logic        pc_advance;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [63:0] sb [$];
   logic [63:0] mon_exp;

   fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .flush(flush), .pc_in(pc_in),
      .pc_advance(pc_advance), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20 && !mem_req_valid; i++) tick();
      check("req_seen", 64'(mem_req_valid), 64'd1);
   endtask

   // Serve one request: optional ready stall, handshake, zero-wait response.
   task automatic serve(input logic [31:0] addr, input logic [31:0] data,
                        input int unsigned stall, input logic [31:0] next_pc);
      wait_req();
      check("req_addr", 64'(mem_req_addr), 64'(addr));
      for (int unsigned i = 0; i < stall; i++) begin
         check("stall_adv", 64'(pc_advance), 64'd0);
         pc_in = pc_in + 32'h40;
         tick();
         check("stall_addr", 64'(mem_req_addr), 64'(addr));
      end
      mem_req_ready = 1'b1;
      #1;
      check("hs_adv", 64'(pc_advance), 64'd1);
      tick();
      mem_req_ready = 1'b0;
      pc_in         = next_pc;
      check("wait_adv", 64'(pc_advance), 64'd0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = data;
      sb.push_back({addr, data});
      tick();
      mem_rsp_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0; fetch_en = 1'b0; flush = 1'b0; pc_in = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; inst_ready = 1'b0;
      tick();
      tick();
      sb.delete();
      reset = 1'b1;
   endtask

   task automatic drain();
      inst_ready = 1'b1;
      repeat (5) tick();
      check("sb_drained", 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (reset && inst_valid && inst_ready) begin
         if (sb.size() == 0) check("sb_empty_pop", 64'(sb.size()), 64'd1);
         else begin
            mon_exp = sb.pop_front();
            check("inst_out", {inst_pc, inst_data}, mon_exp);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      do_reset();
      reset = 1'b0;
      tick();
      check("rst_req_valid", 64'(mem_req_valid), 64'd0);
      check("rst_adv", 64'(pc_advance), 64'd0);
      check("rst_addr", 64'(mem_req_addr), 64'd0);
      check("rst_inst_valid", 64'(inst_valid), 64'd0);
      check("rst_inst", {inst_pc, inst_data}, 64'd0);

      // Reset mid-REQ with a buffered entry
      do_reset();
      fetch_en = 1'b1; pc_in = 32'h7F0;
      serve(32'h7F0, 32'hE0E0_0001, 0, 32'h800);
      check("mid_req_valid", 64'(mem_req_valid), 64'd1);
      check("mid_req_addr", 64'(mem_req_addr), 64'h800);
      reset = 1'b0;
      tick();
      check("mr_req_valid", 64'(mem_req_valid), 64'd0);
      check("mr_inst_valid", 64'(inst_valid), 64'd0);
      check("mr_adv", 64'(pc_advance), 64'd0);
      check("mr_addr", 64'(mem_req_addr), 64'd0);
      reset = 1'b1; fetch_en = 1'b0; sb.delete();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_5555;
      tick();
      mem_rsp_valid = 1'b0;
      tick();
      check("mr_no_push", 64'(inst_valid), 64'd0);

      // Zero-wait stream
      do_reset();
      fetch_en = 1'b1; inst_ready = 1'b1; pc_in = 32'h100;
      serve(32'h100, 32'hAAAA_0001, 0, 32'h104);
      check("stream_back2back", 64'(mem_req_valid), 64'd1);
      serve(32'h104, 32'hAAAA_0002, 0, 32'h108);
      check("stream_third", 64'(mem_req_addr), 64'h108);
      drain();

      // Backpressure until full
      do_reset();
      fetch_en = 1'b1; pc_in = 32'h300;
      serve(32'h300, 32'hD000_0001, 0, 32'h304);
      serve(32'h304, 32'hD000_0002, 0, 32'h308);
      for (int i = 0; i < 4; i++) begin
         check("full_no_req", 64'(mem_req_valid), 64'd0);
         check("full_no_adv", 64'(pc_advance), 64'd0);
         tick();
      end
      check("full_head", {inst_pc, inst_data}, {32'h300, 32'hD000_0001});
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      serve(32'h308, 32'hD000_0003, 0, 32'h30C);
      for (int i = 0; i < 4; i++) begin
         check("one_req_only", 64'(mem_req_valid), 64'd0);
         tick();
      end
      drain();

      // Request stall with changing pc_in
      do_reset();
      fetch_en = 1'b1; inst_ready = 1'b1; pc_in = 32'h400;
      wait_req();
      fetch_en = 1'b0;
      serve(32'h400, 32'hF000_0001, 5, 32'h404);
      check("stall_done", 64'(mem_req_valid), 64'd0);
      drain();

      // Flush in WAIT, late response discarded
      do_reset();
      fetch_en = 1'b1; pc_in = 32'h500;
      serve(32'h500, 32'hB000_0001, 0, 32'h504);
      wait_req();
      mem_req_ready = 1'b1;
      #1;
      check("fw_hs_adv", 64'(pc_advance), 64'd1);
      tick();
      mem_req_ready = 1'b0; flush = 1'b1; pc_in = 32'h200;
      tick();
      flush = 1'b0; sb.delete(); inst_ready = 1'b1;
      check("fw_fifo_empty", 64'(inst_valid), 64'd0);
      check("fw_no_req", 64'(mem_req_valid), 64'd0);
      tick();
      check("fw_drop_hold", 64'(mem_req_valid), 64'd0);
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_DEAD;
      tick();
      mem_rsp_valid = 1'b0;
      check("fw_dead_dropped", 64'(inst_valid), 64'd0);
      serve(32'h200, 32'hB000_0002, 0, 32'h204);
      fetch_en = 1'b0;
      drain();

      // Flush coinciding with handshake
      do_reset();
      fetch_en = 1'b1; inst_ready = 1'b1; pc_in = 32'h600;
      wait_req();
      mem_req_ready = 1'b1; flush = 1'b1;
      #1;
      check("fh_adv_suppressed", 64'(pc_advance), 64'd0);
      tick();
      mem_req_ready = 1'b0; flush = 1'b0; fetch_en = 1'b0;
      check("fh_drop_no_req", 64'(mem_req_valid), 64'd0);
      tick();
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_BEEF;
      tick();
      mem_rsp_valid = 1'b0;
      tick();
      check("fh_rsp_dropped", 64'(inst_valid), 64'd0);
      fetch_en = 1'b1; pc_in = 32'h700;
      serve(32'h700, 32'hC000_0001, 0, 32'h704);
      fetch_en = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly downstream of the instruction pointer and upstream of decode. Samples the current PC and issues a single-outstanding read to instruction memory. Buffers returned words with their PC in a small FIFO for decode, and pulses the IP advance strobe (doNext) on every accepted request. A redirect (doSetIP) flushes buffered and in-flight fetches.

Parameters:
ADDR_W, 32, width of PC and memory address (matches GR_SIZE)
DATA_W, 32, instruction word width
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >= 2)

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-low reset
fetch_en  in  1  doFetch; permits new requests while high
flush  in  1  doSetIP; redirect, discard all buffered/in-flight fetches
pc_in  in  ADDR_W  current PC from instruction pointer, valid every cycle
pc_advance  out  1  doNext; one-cycle pulse when a request is accepted by memory
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  read address
mem_rsp_valid  in  1  read data valid (exactly one per accepted request, in order)
mem_rsp_data  in  DATA_W  read data
inst_valid  out  1  buffer head valid to decode
inst_ready  in  1  decode consumes head
inst_data  out  DATA_W  instruction at buffer head
inst_pc  out  ADDR_W  PC of instruction at buffer head

Behaviour:
- Reset (reset==0 at edge): state IDLE, FIFO empty. Reset values: pc_advance=0, mem_req_valid=0, mem_req_addr=0, inst_valid=0, inst_data=0, inst_pc=0. Reset overrides flush and all handshakes, including mid-request; a response arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DROP.
- IDLE -> REQ when fetch_en=1, flush=0, and free slots (FIFO_DEPTH - count) >= 1. On entry, register mem_req_addr<=pc_in and set mem_req_valid=1 next cycle.
- REQ: mem_req_valid and mem_req_addr are held stable until mem_req_ready=1. On handshake: pc_advance=1 for exactly that cycle (combinational from handshake), then -> WAIT. The request is never withdrawn except on flush or reset.
- WAIT: on mem_rsp_valid, push {pc, data} into the FIFO. Then -> REQ with the new pc_in if the issue conditions hold, else IDLE. Max 1 outstanding request; a request is never issued without a guaranteed free slot, so a response is never dropped for lack of space.
- FIFO: inst_valid = count != 0. Pop on inst_valid & inst_ready. Push and pop in the same cycle are legal when full or empty-plus-push. A pushed entry becomes visible on inst_* the cycle after mem_rsp_valid (1-cycle latency). Pointers wrap modulo FIFO_DEPTH.
- Flush (flush=1, reset=1): FIFO emptied at the edge, so inst_valid=0 the next cycle. Any response arriving in the flush cycle is discarded. pc_advance is forced 0 in the flush cycle.
  - Flush in REQ without handshake: drop request, mem_req_valid=0 next cycle -> IDLE.
  - Flush in REQ with handshake that same cycle: request counts as in-flight -> DROP, pc_advance suppressed.
  - Flush in WAIT: -> DROP, unless mem_rsp_valid is also 1 that cycle, in which case discard it -> IDLE.
  - DROP: discard the next mem_rsp_valid and no push -> IDLE. A further flush while in DROP stays in DROP.
- fetch_en low: no new request is started. A request already in REQ/WAIT completes normally.
- Steady-state throughput with zero-wait memory: one instruction per 2 cycles.

Optional Feature:
FETCH_STATS_EN
- Defined: adds outputs stat_fetched [31:0] and stat_stall [31:0], both reset to 0.
  - stat_fetched increments per FIFO push.
  - stat_stall increments each cycle inst_valid=0 while fetch_en=1.
  - Both saturate at 32'hFFFFFFFF and are not cleared by flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-REQ: assert reset=0 while mem_req_valid=1 -> next cycle mem_req_valid=0, inst_valid=0, pc_advance=0; a response pulse after release produces no push.
- Zero-wait stream: fetch_en=1, pc_in=0x100 then 0x104 after the first advance, mem returns 0xAAAA0001 and 0xAAAA0002, inst_ready=1 -> inst_pc/inst_data = 0x100/0xAAAA0001 then 0x104/0xAAAA0002. pc_advance pulses once per handshake, and new requests issue every 2 cycles.
- Backpressure full: inst_ready=0, FIFO_DEPTH=2 -> exactly 2 entries pushed, then mem_req_valid stays 0 and pc_advance stays 0. Raising inst_ready for one cycle -> exactly one new request issues.
- Request stall: mem_req_ready=0 for 5 cycles with pc_in changing -> mem_req_addr stays at the originally latched value, and pc_advance=1 only in the handshake cycle.
- Flush in WAIT: flush pulsed one cycle, response 0xDEAD arrives 3 cycles later -> 0xDEAD never appears on inst_data, FIFO empty, next request uses the new pc_in=0x200.
- Flush coinciding with handshake: flush=1 in the same cycle as mem_req_ready=1 -> pc_advance=0, FSM enters DROP, and the following response is discarded.
